// File: rtl/pwm_level_sched.sv
// pwm_level_sched: configuration sequencer for LEVEL_COUNT multilevel-PWM carrier slices.
// It divides the carrier range across the slices with a shared restoring divider,
// then writes each slice's band limits over one valid/ready port. When the carrier
// is running, a new configuration is applied only at a carrier-period boundary.
// Optional macro PWM_SYNC_TIMEOUT_EN: forces the boundary after SYNC_TIMEOUT cycles in WAIT_SYNC.
module pwm_level_sched #(
    parameter int LEVEL_COUNT  = 4,
    parameter int BIT_WIDTH    = 16,
    parameter int IDX_W        = 2,
    parameter int SYNC_TIMEOUT = 1024
) (
    input  logic                 MClk,
    input  logic                 RstN,
    input  logic                 CfgValid,
    output logic                 CfgReady,
    input  logic [BIT_WIDTH-1:0] CfgMaxCount,
    input  logic [BIT_WIDTH-1:0] CfgStep,
    input  logic [BIT_WIDTH-1:0] CfgDeadTime,
    input  logic                 SyncPulse,
    output logic                 WrValid,
    input  logic                 WrReady,
    output logic [IDX_W-1:0]     WrLevel,
    output logic [BIT_WIDTH-1:0] WrLower,
    output logic [BIT_WIDTH-1:0] WrUpper,
    output logic [BIT_WIDTH-1:0] StepSize,
    output logic [BIT_WIDTH-1:0] DeadTimeCount,
    output logic                 TWaveEn,
    output logic                 Busy,
    output logic                 CfgError,
    output logic                 SyncTimeout
);

    typedef enum logic [2:0] {S_IDLE, S_DIVIDE, S_WAIT_SYNC, S_WRITE, S_RUN} state_t;

    localparam int CNT_W = $clog2(BIT_WIDTH + 1);
    localparam logic [BIT_WIDTH:0] DIVISOR = (BIT_WIDTH + 1)'(LEVEL_COUNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEVEL_COUNT - 1);

    state_t               state_q, state_d;
    logic [BIT_WIDTH-1:0] step_sh_q, step_sh_d, dead_sh_q, dead_sh_d;
    logic [BIT_WIDTH-1:0] quo_q, quo_d;
    logic [BIT_WIDTH:0]   rem_q, rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0] range_q, range_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BIT_WIDTH-1:0] lower_q, lower_d, upper_q, upper_d;
    logic [BIT_WIDTH-1:0] step_q, step_d, dead_q, dead_d;
    logic                 twave_q, twave_d, err_q, err_d;

    // one restoring-division step: shift in the next dividend bit, subtract if it fits
    logic [BIT_WIDTH:0]   rem_shift, rem_next;
    logic [BIT_WIDTH-1:0] quo_next;
    logic                 qbit;
    logic                 to_hit, sync_go, accept;

    assign rem_shift = {rem_q[BIT_WIDTH-1:0], quo_q[BIT_WIDTH-1]};
    assign qbit      = (rem_shift >= DIVISOR);
    assign rem_next  = qbit ? (rem_shift - DIVISOR) : rem_shift;
    assign quo_next  = {quo_q[BIT_WIDTH-2:0], qbit};

`ifdef PWM_SYNC_TIMEOUT_EN
    localparam int TO_W = $clog2(SYNC_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    assign to_hit = (state_q == S_WAIT_SYNC) && !SyncPulse &&
                    (to_cnt_q == TO_W'(SYNC_TIMEOUT - 1));

    // timeout counter only advances while waiting for the carrier boundary
    always_comb begin
        to_cnt_d = '0;
        if (state_q == S_WAIT_SYNC) to_cnt_d = to_cnt_q + 1'b1;
    end

    // timeout counter register
    always_ff @(posedge MClk) begin
        if (!RstN) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end
`else
    logic unused_sync_timeout;
    assign unused_sync_timeout = (SYNC_TIMEOUT != 0);
    assign to_hit = 1'b0;
`endif

    assign SyncTimeout   = to_hit;
    assign sync_go       = SyncPulse || to_hit;
    assign CfgReady      = (state_q == S_IDLE) || (state_q == S_RUN);
    assign accept        = CfgValid && CfgReady;
    assign Busy          = (state_q == S_DIVIDE) || (state_q == S_WAIT_SYNC) || (state_q == S_WRITE);
    assign WrValid       = (state_q == S_WRITE);
    assign WrLevel       = idx_q;
    assign WrLower       = lower_q;
    assign WrUpper       = upper_q;
    assign StepSize      = step_q;
    assign DeadTimeCount = dead_q;
    assign TWaveEn       = twave_q;
    assign CfgError      = err_q;

    // next-state and datapath: accept, divide, wait for boundary, write bands
    always_comb begin
        state_d   = state_q;
        step_sh_d = step_sh_q;
        dead_sh_d = dead_sh_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        range_d   = range_q;
        idx_d     = idx_q;
        lower_d   = lower_q;
        upper_d   = upper_q;
        step_d    = step_q;
        dead_d    = dead_q;
        twave_d   = twave_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (accept) begin
                    step_sh_d = CfgStep;
                    dead_sh_d = CfgDeadTime;
                    quo_d     = CfgMaxCount;
                    rem_d     = '0;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    state_d   = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                quo_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIT_WIDTH - 1)) begin
                    range_d = quo_next;
                    idx_d   = '0;
                    lower_d = '0;
                    upper_d = quo_next - 1'b1;
                    if (quo_next == '0) begin
                        // zero-width bands: keep whatever the slices already run
                        err_d   = 1'b1;
                        range_d = range_q;
                        lower_d = lower_q;
                        upper_d = upper_q;
                        state_d = twave_q ? S_RUN : S_IDLE;
                    end else begin
                        state_d = twave_q ? S_WAIT_SYNC : S_WRITE;
                    end
                end
            end
            S_WAIT_SYNC: begin
                if (sync_go) begin
                    twave_d = 1'b0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (WrReady) begin
                    if (idx_q == LAST_IDX) begin
                        step_d  = step_sh_q;
                        dead_d  = dead_sh_q;
                        twave_d = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        // next band starts right after the previous one
                        idx_d   = idx_q + 1'b1;
                        lower_d = upper_q + 1'b1;
                        upper_d = upper_q + range_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge MClk) begin
        if (!RstN) begin
            state_q   <= S_IDLE;
            step_sh_q <= '0;
            dead_sh_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            range_q   <= '0;
            idx_q     <= '0;
            lower_q   <= '0;
            upper_q   <= '0;
            step_q    <= '0;
            dead_q    <= '0;
            twave_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_sh_q <= step_sh_d;
            dead_sh_q <= dead_sh_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            range_q   <= range_d;
            idx_q     <= idx_d;
            lower_q   <= lower_d;
            upper_q   <= upper_d;
            step_q    <= step_d;
            dead_q    <= dead_d;
            twave_q   <= twave_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_pwm_level_sched.sv
// Directed bench for pwm_level_sched: table of configurations plus hand sequences
// for reconfiguration in RUN, mid-write reset and the WAIT_SYNC timeout.
module tb_pwm_level_sched;

    localparam int LC = 4;
    localparam int BW = 16;
    localparam int IW = 2;

    logic          MClk = 1'b0;
    logic          RstN;
    logic          CfgValid;
    logic          CfgReady;
    logic [BW-1:0] CfgMaxCount, CfgStep, CfgDeadTime;
    logic          SyncPulse;
    logic          WrValid;
    logic          WrReady;
    logic [IW-1:0] WrLevel;
    logic [BW-1:0] WrLower, WrUpper, StepSize, DeadTimeCount;
    logic          TWaveEn, Busy, CfgError, SyncTimeout;

    pwm_level_sched #(.LEVEL_COUNT(LC), .BIT_WIDTH(BW), .IDX_W(IW), .SYNC_TIMEOUT(1024)) dut (
        .MClk(MClk), .RstN(RstN), .CfgValid(CfgValid), .CfgReady(CfgReady),
        .CfgMaxCount(CfgMaxCount), .CfgStep(CfgStep), .CfgDeadTime(CfgDeadTime),
        .SyncPulse(SyncPulse), .WrValid(WrValid), .WrReady(WrReady), .WrLevel(WrLevel),
        .WrLower(WrLower), .WrUpper(WrUpper), .StepSize(StepSize),
        .DeadTimeCount(DeadTimeCount), .TWaveEn(TWaveEn), .Busy(Busy),
        .CfgError(CfgError), .SyncTimeout(SyncTimeout)
    );

    always #5 MClk = ~MClk;

    typedef struct packed {
        logic              rst;
        logic [BW-1:0]     mx;
        logic [BW-1:0]     st;
        logic [BW-1:0]     dt;
        logic              tog;
        logic              err;
        int                tw;
        logic [3:0][BW-1:0] lo;
        logic [3:0][BW-1:0] hi;
    } vec_t;

    vec_t tbl[6];

    int nvec = 0;
    int nerr = 0;

    int cyc, first_vld, tw_rise, tw_fall, err_cyc, n_hs, stab_bad, to_cyc;
    logic tw_at_sync;
    logic [IW-1:0] g_lvl[8];
    logic [BW-1:0] g_lo[8];
    logic [BW-1:0] g_hi[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge MClk);
        #1;
    endtask

    task automatic do_reset();
        RstN = 1'b0;
        tick();
        RstN = 1'b1;
        chk("rst_cfg_ready", 32'(CfgReady), 1);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_wr_valid", 32'(WrValid), 0);
        chk("rst_twave", 32'(TWaveEn), 0);
        chk("rst_err", 32'(CfgError), 0);
        chk("rst_step", 32'(StepSize), 0);
        chk("rst_dead", 32'(DeadTimeCount), 0);
        chk("rst_wr_bus", {WrLower, WrUpper}, 0);
    endtask

    // drive one accepted request; afterwards cyc is 1 (first cycle after the accept edge)
    task automatic accept(input logic [BW-1:0] mx, input logic [BW-1:0] st, input logic [BW-1:0] dt);
        CfgValid = 1'b1;
        CfgMaxCount = mx;
        CfgStep = st;
        CfgDeadTime = dt;
        chk("cfg_ready", 32'(CfgReady), 1);
        tick();
        CfgValid = 1'b0;
        cyc = 1;
    endtask

    // run until the band writes finish (or an error settles, or the budget runs out)
    task automatic drain(input int budget, input bit tog, input int sync_at);
        bit [3:0] pat = 4'b1001;
        int vcnt = 0;
        logic pv = 1'b0;
        logic [IW-1:0] sl = '0;
        logic [BW-1:0] slo = '0, shi = '0;
        first_vld = -1; tw_rise = -1; tw_fall = -1; err_cyc = -1; to_cyc = -1;
        n_hs = 0; stab_bad = 0; tw_at_sync = 1'b0;
        while (cyc < budget) begin
            if (n_hs >= LC && TWaveEn) begin
                tw_rise = cyc;
                break;
            end
            if (err_cyc > 0 && !Busy) break;
            SyncPulse = (cyc == sync_at);
            if (cyc == sync_at) tw_at_sync = TWaveEn;
            if (!TWaveEn && tw_fall < 0) tw_fall = cyc;
            if (SyncTimeout && to_cyc < 0) to_cyc = cyc;
            if (CfgError && err_cyc < 0) err_cyc = cyc;
            if (pv && (!WrValid || WrLevel != sl || WrLower != slo || WrUpper != shi)) stab_bad++;
            if (WrValid) begin
                if (first_vld < 0) first_vld = cyc;
                WrReady = tog ? pat[vcnt % 4] : 1'b1;
                vcnt++;
            end else begin
                WrReady = 1'b0;
            end
            if (WrValid && WrReady) begin
                if (n_hs < 8) begin
                    g_lvl[n_hs] = WrLevel;
                    g_lo[n_hs] = WrLower;
                    g_hi[n_hs] = WrUpper;
                end
                n_hs++;
            end
            pv = WrValid && !WrReady;
            sl = WrLevel; slo = WrLower; shi = WrUpper;
            tick();
            cyc++;
        end
        SyncPulse = 1'b0;
        WrReady = 1'b0;
    endtask

    task automatic check_writes(input logic [3:0][BW-1:0] lo, input logic [3:0][BW-1:0] hi);
        chk("handshakes", n_hs, LC);
        chk("stable_while_stalled", stab_bad, 0);
        for (int i = 0; i < LC; i++) begin
            chk($sformatf("wr%0d_level", i), 32'(g_lvl[i]), i);
            chk($sformatf("wr%0d_lower", i), 32'(g_lo[i]), 32'(lo[i]));
            chk($sformatf("wr%0d_upper", i), 32'(g_hi[i]), 32'(hi[i]));
        end
    endtask

    localparam logic [3:0][BW-1:0] LO1000 = {16'd750, 16'd500, 16'd250, 16'd0};
    localparam logic [3:0][BW-1:0] HI1000 = {16'd999, 16'd749, 16'd499, 16'd249};
    localparam logic [3:0][BW-1:0] LO2000 = {16'd1500, 16'd1000, 16'd500, 16'd0};
    localparam logic [3:0][BW-1:0] HI2000 = {16'd1999, 16'd1499, 16'd999, 16'd499};

    initial begin
        RstN = 1'b0; CfgValid = 1'b0; CfgMaxCount = '0; CfgStep = '0; CfgDeadTime = '0;
        SyncPulse = 1'b0; WrReady = 1'b0;
        tick();
        tick();

        tbl[0] = '{rst: 1, mx: 1000, st: 3, dt: 7, tog: 0, err: 0, tw: 21, lo: LO1000, hi: HI1000};
        tbl[1] = '{rst: 1, mx: 3, st: 1, dt: 1, tog: 0, err: 1, tw: -1, lo: '0, hi: '0};
        tbl[2] = '{rst: 0, mx: 1003, st: 2, dt: 4, tog: 0, err: 0, tw: 21, lo: LO1000, hi: HI1000};
        tbl[3] = '{rst: 1, mx: 1000, st: 6, dt: 8, tog: 1, err: 0, tw: 25, lo: LO1000, hi: HI1000};
        tbl[4] = '{rst: 1, mx: 4, st: 1, dt: 0, tog: 0, err: 0, tw: 21,
                   lo: {16'd3, 16'd2, 16'd1, 16'd0}, hi: {16'd3, 16'd2, 16'd1, 16'd0}};
        tbl[5] = '{rst: 1, mx: 65535, st: 9, dt: 11, tog: 0, err: 0, tw: 21,
                   lo: {16'd49149, 16'd32766, 16'd16383, 16'd0},
                   hi: {16'd65531, 16'd49148, 16'd32765, 16'd16382}};

        for (int v = 0; v < 6; v++) begin
            if (tbl[v].rst) do_reset();
            accept(tbl[v].mx, tbl[v].st, tbl[v].dt);
            chk("busy_after_accept", 32'(Busy), 1);
            chk("err_cleared_on_accept", 32'(CfgError), 0);
            drain(80, tbl[v].tog, -1);
            if (tbl[v].err) begin
                chk("err_no_writes", first_vld, -1);
                chk("err_cycle", err_cyc, 17);
                chk("err_twave_off", 32'(TWaveEn), 0);
                chk("err_idle_ready", {31'd0, CfgReady}, 1);
            end else begin
                chk("first_wrvalid_cycle", first_vld, 17);
                chk("twave_rise_cycle", tw_rise, tbl[v].tw);
                check_writes(tbl[v].lo, tbl[v].hi);
                chk("step_loaded", 32'(StepSize), 32'(tbl[v].st));
                chk("dead_loaded", 32'(DeadTimeCount), 32'(tbl[v].dt));
                chk("run_not_busy", 32'(Busy), 0);
            end
        end

        // reset right after the idx=1 handshake, then a fresh config
        do_reset();
        accept(1000, 3, 7);
        WrReady = 1'b1;
        while (cyc < 19) begin
            tick();
            cyc++;
        end
        chk("mid_write_level", 32'(WrLevel), 2);
        RstN = 1'b0;
        tick();
        RstN = 1'b1;
        WrReady = 1'b0;
        chk("abort_cfg_ready", 32'(CfgReady), 1);
        chk("abort_quiet", {WrValid, Busy, TWaveEn, CfgError, SyncTimeout}, 0);
        chk("abort_bus", {WrLevel, WrLower, WrUpper}, 0);
        accept(1000, 3, 7);
        drain(80, 1'b0, -1);
        chk("fresh_twave_rise", tw_rise, 21);
        check_writes(LO1000, HI1000);

        // reconfigure while running: writes wait for the carrier boundary
        accept(2000, 5, 9);
        chk("run_accept_twave_kept", 32'(TWaveEn), 1);
        drain(120, 1'b0, 40);
        chk("twave_held_until_sync", 32'(tw_at_sync), 1);
        chk("twave_fall_cycle", tw_fall, 41);
        chk("first_write_after_sync", first_vld, 41);
        chk("reconf_twave_rise", tw_rise, 45);
        check_writes(LO2000, HI2000);
        chk("reconf_step", 32'(StepSize), 5);
        chk("reconf_dead", 32'(DeadTimeCount), 9);

        // no SyncPulse at all
        accept(1000, 1, 1);
`ifdef PWM_SYNC_TIMEOUT_EN
        drain(1200, 1'b0, -1);
        chk("timeout_pulse_cycle", to_cyc, 1040);
        chk("timeout_twave_fall", tw_fall, 1041);
        check_writes(LO1000, HI1000);
        chk("timeout_step", 32'(StepSize), 1);
`else
        drain(1100, 1'b0, -1);
        chk("nosync_still_busy", 32'(Busy), 1);
        chk("nosync_no_writes", n_hs, 0);
        chk("nosync_no_timeout", to_cyc, -1);
        chk("nosync_twave_on", 32'(TWaveEn), 1);
        chk("nosync_old_step", 32'(StepSize), 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
